pc_gen: RTL and testbench
=========================

# pc_gen

Parametrised fetch program-counter generator for the single-issue pipeline. It holds the instruction address presented to instruction memory/cache and advances it by one instruction per unstalled cycle. It arbitrates among trap, jump, conditional-branch and jump-register redirects. Unlike the previous PC block, redirects that arrive during a stall are buffered until the stall ends, and the block has a boot/halt state machine.

## Interface
- `ADDR_W`, 32, width of all addresses.
- `INST_BYTES`, 4, sequential increment; power of two, at least 1.
- `RESET_VEC`, 32'h0000_0000, address fetched first after reset.
- `TRAP_VEC`, 32'h0000_0080, target used on trap and on alignment fault.

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `stall_pc` in 1: when 1, hold `inst_address`.
- `trap` in 1: redirect to `TRAP_VEC`.
- `jump_n` in 1: unconditional jump, active-low.
- `jump_address` in ADDR_W: target for `jump_n`.
- `ebranch` in 1: taken conditional branch.
- `bgtz_sig` in 1: taken BGTZ branch.
- `jc_instaddress` in ADDR_W: target for both branch types.
- `jmp_reg` in 1: jump-register.
- `rrs` in ADDR_W: target for `jmp_reg`.
- `halt` in 1: freeze fetch.
- `inst_address` out ADDR_W: current fetch PC, registered.
- `next_instaddress` out ADDR_W: `inst_address + INST_BYTES`, combinational.
- `ce` out 1: fetch enable, registered.
- `pend_valid` out 1: a buffered redirect is waiting.
- `halted` out 1: the state machine is in HALT.
- `align_err` out 1: one-cycle pulse on a misaligned target.

## Operation
- **Redirect priority:** `trap` first, then `!jump_n`, then `ebranch|bgtz_sig`, then `jmp_reg`, then sequential (`next_instaddress`). Only the highest-priority live source is used.
- **State machine** (BOOT, RUN, HALT):
  - BOOT: `ce`=0 and PC held at `RESET_VEC`. Go to RUN unconditionally on the next edge.
  - RUN: normal fetch.
  - RUN goes to HALT when `halt`=1 and `stall_pc`=0. The PC freezes at its current value and `ce` stays 1.
  - HALT goes to RUN only when `trap`=1. The PC loads `TRAP_VEC`. All other inputs are ignored in HALT.
- **RUN with `stall_pc`=0:**
  - If a live redirect exists, the PC loads its target.
  - Otherwise, if `pend_valid`, the PC loads the pending target.
  - Otherwise, the PC loads `next_instaddress`.
  - `pend_valid` clears in every case, with one exception: a pending trap beats a live non-trap redirect.
- **RUN with `stall_pc`=1:**
  - The PC holds.
  - A live redirect is captured into the pending register and sets `pend_valid`.
  - A newer capture overwrites an older one, except that a pending trap is never overwritten by a non-trap redirect.
- **Arithmetic:** all sums are modulo 2^ADDR_W. For example, `inst_address` = all-ones − 3 with `INST_BYTES`=4 wraps to 0.
- **Alignment:** a target is misaligned if any of its low log2(`INST_BYTES`) bits are nonzero. Behaviour is set by the macro in Configuration.

## Timing
- **Reset values while `rst`=1:**
  - `inst_address` = `RESET_VEC`, `ce`=0, `pend_valid`=0, `halted`=0, `align_err`=0, state BOOT.
  - Reset asserted mid-operation discards any pending redirect immediately, without waiting for a clock edge.
- **After reset deasserts:**
  - 1st edge: `ce`=1, PC still `RESET_VEC`.
  - 2nd edge: first advance or redirect.
- **Redirect latency:** one edge. A redirect sampled at edge N appears on `inst_address` after edge N.
- **Stalled redirect:** applied on the first edge with `stall_pc`=0, even if the source has already dropped.
- **`align_err`:** high for exactly the one cycle following the faulting edge.

## Configuration
- `PC_ALIGN_CHK_EN` defined:
  - A misaligned chosen target (jump, branch, jump-register or pending) is replaced by `TRAP_VEC` and `align_err` pulses.
  - Misaligned `RESET_VEC`/`TRAP_VEC` parameters are an elaboration error.
- `PC_ALIGN_CHK_EN` not defined:
  - The low log2(`INST_BYTES`) bits of every chosen target are forced to 0.
  - `align_err` is tied to 0.

## Structure
- Package `pc_pkg`:
  - state enum BOOT/RUN/HALT;
  - redirect-source enum NONE/SEQ/JREG/BR/JMP/TRAP, ordered by priority;
  - a helper constant for log2(`INST_BYTES`).
- Sub-module `pc_redirect_arb`: combinational priority encoder that outputs the selected source and target.
- Top level holds the state machine, the PC register, the pending register and the alignment logic.

## Test plan
- **Reset release:** deassert `rst`, no redirects, `INST_BYTES`=4 -> `ce` 0→1 at edge 1; `inst_address` 0, 0, 4, 8 over edges 0–3.
- **Priority:** `trap`=1, `jump_n`=0, `ebranch`=1, `jmp_reg`=1 in one cycle -> PC=0x80; repeat without `trap` -> PC=`jump_address`.
- **Buffered redirect:**
  - Stall 3 cycles, `ebranch` with `jc_instaddress`=0x100 pulsed only in stall cycle 1 -> `pend_valid`=1.
  - After release, PC=0x100 and `pend_valid`=0.
- **Trap retention:** while stalled, `trap` then `jmp_reg` with `rrs`=0x200 -> after release, PC=0x80.
- **Halt:** `halt`=1 at PC=0x40 -> `halted`=1, PC stays 0x40 for 10 cycles despite `jump_n`=0; then `trap` -> PC=0x80, `halted`=0.
- **Alignment and wrap:**
  - `jump_address`=0x102 -> with `PC_ALIGN_CHK_EN`: PC=0x80 and a one-cycle `align_err`; without it: PC=0x100.
  - PC=0xFFFF_FFFC advancing -> 0x0.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types for the fetch PC generator: FSM states, redirect sources
// (ordered by priority) and the address-LSB helper.
package pc_pkg;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_HALT
  } pc_state_e;

  // Numeric order is priority order; anything above SRC_SEQ is a redirect.
  typedef enum logic [2:0] {
    SRC_NONE,
    SRC_SEQ,
    SRC_JREG,
    SRC_BR,
    SRC_JMP,
    SRC_TRAP
  } pc_src_e;

  // Number of address LSBs covered by one instruction (log2 of INST_BYTES).
  function automatic int unsigned pc_lsb_w(input int unsigned inst_bytes);
    return $clog2(inst_bytes);
  endfunction

endpackage

// File: rtl/pc_redirect_arb.sv
// Combinational priority encoder choosing the live redirect source and its
// target: trap > jump > branch > jump-register > sequential.
module pc_redirect_arb
  import pc_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] TRAP_VEC = ADDR_W'('h80)
) (
  input  logic              trap_i,
  input  logic              jump_n_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              ebranch_i,
  input  logic              bgtz_i,
  input  logic [ADDR_W-1:0] br_addr_i,
  input  logic              jmp_reg_i,
  input  logic [ADDR_W-1:0] rrs_i,
  input  logic [ADDR_W-1:0] seq_addr_i,
  output logic [2:0]        src_o,
  output logic [ADDR_W-1:0] target_o
);

  pc_src_e src;

  always_comb begin
    src      = SRC_SEQ;
    target_o = seq_addr_i;
    if (trap_i) begin
      src      = SRC_TRAP;
      target_o = TRAP_VEC;
    end else if (!jump_n_i) begin
      src      = SRC_JMP;
      target_o = jump_addr_i;
    end else if (ebranch_i || bgtz_i) begin
      src      = SRC_BR;
      target_o = br_addr_i;
    end else if (jmp_reg_i) begin
      src      = SRC_JREG;
      target_o = rrs_i;
    end
  end

  assign src_o = src;

endmodule

// File: rtl/pc_gen.sv
// Fetch program-counter generator with boot/run/halt FSM and a one-deep
// buffer for redirects arriving during a stall. Define PC_ALIGN_CHK_EN to
// trap on misaligned targets; otherwise their low bits are cleared.
module pc_gen
  import pc_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                INST_BYTES = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC  = '0,
  parameter logic [ADDR_W-1:0] TRAP_VEC   = ADDR_W'('h80)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_pc,
  input  logic              trap,
  input  logic              jump_n,
  input  logic [ADDR_W-1:0] jump_address,
  input  logic              ebranch,
  input  logic              bgtz_sig,
  input  logic [ADDR_W-1:0] jc_instaddress,
  input  logic              jmp_reg,
  input  logic [ADDR_W-1:0] rrs,
  input  logic              halt,
  output logic [ADDR_W-1:0] inst_address,
  output logic [ADDR_W-1:0] next_instaddress,
  output logic              ce,
  output logic              pend_valid,
  output logic              halted,
  output logic              align_err
);

  localparam int unsigned       LSB_W    = pc_lsb_w(INST_BYTES);
  localparam logic [ADDR_W-1:0] LSB_MASK = ADDR_W'((64'd1 << LSB_W) - 64'd1);

  pc_state_e         state_q, state_d;
  pc_src_e           pend_src_q, pend_src_d, live_src;
  logic [ADDR_W-1:0] pc_q, pc_d, pend_addr_q, pend_addr_d, arb_target, chosen;
  logic [ADDR_W:0]   fixed;
  logic [2:0]        arb_src;
  logic              ce_q, align_err_q, align_err_d, live, pend_is_trap;

`ifdef PC_ALIGN_CHK_EN
  if (((RESET_VEC & LSB_MASK) != '0) || ((TRAP_VEC & LSB_MASK) != '0)) begin : g_vec_align
    $error("pc_gen: RESET_VEC or TRAP_VEC is not instruction aligned");
  end

  // MSB flags a fault; the faulting target is redirected to the trap vector.
  function automatic logic [ADDR_W:0] fix_target(input logic [ADDR_W-1:0] a);
    if ((a & LSB_MASK) != '0) return {1'b1, TRAP_VEC};
    return {1'b0, a};
  endfunction
`else
  function automatic logic [ADDR_W:0] fix_target(input logic [ADDR_W-1:0] a);
    return {1'b0, a & ~LSB_MASK};
  endfunction
`endif

  assign next_instaddress = pc_q + ADDR_W'(INST_BYTES);

  pc_redirect_arb #(
    .ADDR_W  (ADDR_W),
    .TRAP_VEC(TRAP_VEC)
  ) u_arb (
    .trap_i     (trap),
    .jump_n_i   (jump_n),
    .jump_addr_i(jump_address),
    .ebranch_i  (ebranch),
    .bgtz_i     (bgtz_sig),
    .br_addr_i  (jc_instaddress),
    .jmp_reg_i  (jmp_reg),
    .rrs_i      (rrs),
    .seq_addr_i (next_instaddress),
    .src_o      (arb_src),
    .target_o   (arb_target)
  );

  assign live_src     = pc_src_e'(arb_src);
  assign live         = (live_src > SRC_SEQ);
  assign pend_is_trap = (pend_src_q == SRC_TRAP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_BOOT;
      pc_q        <= RESET_VEC;
      ce_q        <= 1'b0;
      pend_src_q  <= SRC_NONE;
      align_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ce_q        <= 1'b1;
      pend_src_q  <= pend_src_d;
      align_err_q <= align_err_d;
    end
  end

  always_ff @(posedge clk) begin
    pend_addr_q <= pend_addr_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN:  if (halt && !stall_pc) state_d = ST_HALT;
      ST_HALT: if (trap) state_d = ST_RUN;
      default: state_d = ST_BOOT;
    endcase
  end

  always_comb begin
    pc_d        = pc_q;
    pend_src_d  = pend_src_q;
    pend_addr_d = pend_addr_q;
    align_err_d = 1'b0;
    chosen      = next_instaddress;
    fixed       = '0;
    case (state_q)
      ST_RUN: begin
        if (stall_pc) begin
          // A buffered trap survives any later non-trap redirect.
          if (live && !(pend_is_trap && live_src != SRC_TRAP)) begin
            pend_src_d  = live_src;
            pend_addr_d = arb_target;
          end
        end else if (!halt) begin
          if (pend_is_trap)                  chosen = TRAP_VEC;
          else if (live)                     chosen = arb_target;
          else if (pend_src_q != SRC_NONE)   chosen = pend_addr_q;
          fixed       = fix_target(chosen);
          pc_d        = fixed[ADDR_W-1:0];
          align_err_d = fixed[ADDR_W];
          pend_src_d  = SRC_NONE;
        end
      end
      ST_HALT: begin
        if (trap) begin
          fixed       = fix_target(TRAP_VEC);
          pc_d        = fixed[ADDR_W-1:0];
          align_err_d = fixed[ADDR_W];
          pend_src_d  = SRC_NONE;
        end
      end
      default: pc_d = RESET_VEC;
    endcase
  end

  assign inst_address = pc_q;
  assign ce           = ce_q;
  assign pend_valid   = (pend_src_q != SRC_NONE);
  assign halted       = (state_q == ST_HALT);
`ifdef PC_ALIGN_CHK_EN
  assign align_err    = align_err_q;
`else
  assign align_err    = 1'b0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Randomized bench for pc_gen against a behavioural model of the fetch-PC rules.
module tb_pc_gen;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0080;
  localparam int unsigned IB = 4;

  logic        clk = 1'b0, rst = 1'b1;
  logic        stall_pc = 0, trap = 0, jump_n = 1, ebranch = 0, bgtz_sig = 0, jmp_reg = 0, halt = 0;
  logic [31:0] jump_address = 0, jc_instaddress = 0, rrs = 0;
  logic [31:0] inst_address, next_instaddress;
  logic        ce, pend_valid, halted, align_err;

  int n_checks = 0, n_fail = 0;

  // Model state
  logic [31:0] m_pc, m_paddr;
  bit          m_ce, m_boot, m_halt, m_pv, m_ptrap, m_aerr;

  pc_gen dut (
    .clk(clk), .rst(rst), .stall_pc(stall_pc), .trap(trap), .jump_n(jump_n),
    .jump_address(jump_address), .ebranch(ebranch), .bgtz_sig(bgtz_sig),
    .jc_instaddress(jc_instaddress), .jmp_reg(jmp_reg), .rrs(rrs), .halt(halt),
    .inst_address(inst_address), .next_instaddress(next_instaddress), .ce(ce),
    .pend_valid(pend_valid), .halted(halted), .align_err(align_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RV; m_ce = 0; m_boot = 1; m_halt = 0; m_pv = 0; m_ptrap = 0; m_aerr = 0;
  endtask

  function automatic logic [31:0] fix(input logic [31:0] a, output bit err);
    err = 0;
`ifdef PC_ALIGN_CHK_EN
    if (a % IB != 0) begin err = 1; return TV; end
    return a;
`else
    return a - (a % IB);
`endif
  endfunction

  // Apply one clock edge's worth of the fetch rules to the model.
  task automatic model_edge();
    bit live, ltrap, err;
    logic [31:0] ltgt, tgt;
    live = 1; ltrap = 0; ltgt = 0; err = 0;
    if (trap)                      begin ltgt = TV; ltrap = 1; end
    else if (!jump_n)              ltgt = jump_address;
    else if (ebranch || bgtz_sig)  ltgt = jc_instaddress;
    else if (jmp_reg)              ltgt = rrs;
    else                           live = 0;
    m_aerr = 0;
    if (m_boot) begin
      m_boot = 0;
    end else if (m_halt) begin
      if (trap) begin m_halt = 0; m_pc = fix(TV, err); m_aerr = err; m_pv = 0; end
    end else if (stall_pc) begin
      if (live && !(m_pv && m_ptrap && !ltrap)) begin
        m_pv = 1; m_ptrap = ltrap; m_paddr = ltgt;
      end
    end else if (halt) begin
      m_halt = 1;
    end else begin
      if (m_pv && m_ptrap) tgt = TV;
      else if (live)       tgt = ltgt;
      else if (m_pv)       tgt = m_paddr;
      else                 tgt = m_pc + IB;
      m_pc = fix(tgt, err);
      m_aerr = err;
      m_pv = 0;
    end
    m_ce = 1;
  endtask

  task automatic compare_all();
    check("pc", inst_address, m_pc);
    check("next_pc", next_instaddress, m_pc + IB);
    check("ce", 32'(ce), 32'(m_ce));
    check("pend_valid", 32'(pend_valid), 32'(m_pv));
    check("halted", 32'(halted), 32'(m_halt));
    check("align_err", 32'(align_err), 32'(m_aerr));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    stall_pc = 0; trap = 0; jump_n = 1; ebranch = 0; bgtz_sig = 0; jmp_reg = 0; halt = 0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
    return a;
  endfunction

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    check("rst_pc", inst_address, 32'h0);
    check("rst_ce", 32'(ce), 32'd0);

    // Reset release and sequential fetch
    rst = 0;
    step(); check("boot_ce", 32'(ce), 32'd1); check("boot_pc", inst_address, 32'h0);
    step(); check("seq1", inst_address, 32'h4);
    step(); check("seq2", inst_address, 32'h8);

    // Priority
    trap = 1; jump_n = 0; ebranch = 1; jmp_reg = 1;
    jump_address = 32'h300; jc_instaddress = 32'h400; rrs = 32'h500;
    step(); check("prio_trap", inst_address, 32'h80);
    trap = 0;
    step(); check("prio_jump", inst_address, 32'h300);
    jump_n = 1;
    step(); check("prio_br", inst_address, 32'h400);
    idle_inputs();

    // Buffered branch across a 3-cycle stall
    stall_pc = 1; ebranch = 1; jc_instaddress = 32'h100;
    step(); ebranch = 0;
    step(); step();
    check("buf_pend", 32'(pend_valid), 32'd1);
    stall_pc = 0;
    step(); check("buf_pc", inst_address, 32'h100); check("buf_clr", 32'(pend_valid), 32'd0);

    // Trap retention under stall
    stall_pc = 1; trap = 1;
    step(); trap = 0; jmp_reg = 1; rrs = 32'h200;
    step(); jmp_reg = 0; stall_pc = 0;
    step(); check("trap_keep", inst_address, 32'h80);

    // Halt
    jump_n = 0; jump_address = 32'h40;
    step(); jump_n = 1; halt = 1;
    step(); check("halt_on", 32'(halted), 32'd1); check("halt_pc", inst_address, 32'h40);
    halt = 0; jump_n = 0; jump_address = 32'h600;
    for (int i = 0; i < 10; i++) step();
    check("halt_hold", inst_address, 32'h40);
    jump_n = 1; trap = 1;
    step(); check("halt_exit", inst_address, 32'h80); check("halt_off", 32'(halted), 32'd0);
    trap = 0;

    // Misaligned jump
    jump_n = 0; jump_address = 32'h102;
    step();
`ifdef PC_ALIGN_CHK_EN
    check("align_trap", inst_address, 32'h80); check("align_err", 32'(align_err), 32'd1);
`else
    check("align_mask", inst_address, 32'h100);
`endif
    jump_n = 1;
    step(); check("align_pulse", 32'(align_err), 32'd0);

    // Wrap
    jump_n = 0; jump_address = 32'hFFFF_FFFC;
    step(); jump_n = 1;
    step(); check("wrap", inst_address, 32'h0);

    // Asynchronous reset drops a pending redirect immediately
    stall_pc = 1; ebranch = 1; jc_instaddress = 32'h700;
    step(); check("pre_rst_pend", 32'(pend_valid), 32'd1);
    rst = 1; #1;
    model_reset();
    check("arst_pend", 32'(pend_valid), 32'd0);
    check("arst_pc", inst_address, RV);
    check("arst_ce", 32'(ce), 32'd0);
    @(posedge clk); #1;
    idle_inputs(); rst = 0;

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      stall_pc       = ($urandom_range(0, 99) < 30);
      trap           = ($urandom_range(0, 99) < 5);
      jump_n         = !($urandom_range(0, 99) < 10);
      ebranch        = ($urandom_range(0, 99) < 8);
      bgtz_sig       = ($urandom_range(0, 99) < 5);
      jmp_reg        = ($urandom_range(0, 99) < 8);
      halt           = ($urandom_range(0, 99) < 3);
      jump_address   = rand_addr();
      jc_instaddress = rand_addr();
      rrs            = rand_addr();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
